// File: rtl/peripheral_memory_bridge.sv
// peripheral_memory_bridge: single-outstanding request/response master for a
// peripheral memory port. Accepts one read or write on the request channel,
// drives one memory strobe, waits a fixed read latency and returns exactly one
// response. Out-of-range addresses produce an error response with no access.
// Every output comes straight from a register.

module peripheral_memory_bridge #(
   parameter int unsigned DATAWIDTH    = 32,
   parameter int unsigned DATADEPTH    = 256,
   parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH),
   parameter int unsigned REQADDRWIDTH = 16,
   parameter int unsigned READLATENCY  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   // request channel
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [REQADDRWIDTH-1:0] req_address,
   input  logic [DATAWIDTH-1:0]    req_data,
   // response channel
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATAWIDTH-1:0]    resp_data,
   output logic                    resp_error,
   // memory side
   output logic [ADDRESSWIDTH-1:0] address,
   output logic [DATAWIDTH-1:0]    data_in,
   input  logic [DATAWIDTH-1:0]    data_out,
   output logic                    write_en,
   output logic                    read_en
);

   // Wide enough for a read latency of up to 4 (counts READLATENCY-1 down to 0).
   localparam int unsigned CntW = 3;

   // One extra bit so the depth itself is representable even when it equals
   // 2**REQADDRWIDTH.
   localparam logic [REQADDRWIDTH:0] DepthLim = (REQADDRWIDTH + 1)'(DATADEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   state_e                  state_q, state_d;
   logic                    req_write_q, req_write_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    req_ready_q, req_ready_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [DATAWIDTH-1:0]    resp_data_q, resp_data_d;
   logic                    resp_error_q, resp_error_d;
   logic [ADDRESSWIDTH-1:0] address_q, address_d;
   logic [DATAWIDTH-1:0]    data_in_q, data_in_d;
   logic                    write_en_q, write_en_d;
   logic                    read_en_q, read_en_d;

   logic req_fire;
   logic addr_oor;

   assign req_fire = req_valid && req_ready_q;
   assign addr_oor = ({1'b0, req_address} >= DepthLim);

   // Next-state and next-output logic; every register holds unless changed,
   // except the strobes which default low so they last exactly one cycle.
   always_comb begin
      state_d      = state_q;
      req_write_d  = req_write_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      address_d    = address_q;
      data_in_d    = data_in_q;
      write_en_d   = 1'b0;
      read_en_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (req_fire) begin
               req_write_d = req_write;
               if (addr_oor) begin
                  // Rejected without touching the memory side.
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_data_d  = '0;
               end else begin
                  // Strobe and address registered here so they are live
                  // throughout the ISSUE cycle.
                  state_d    = StIssue;
                  address_d  = req_address[ADDRESSWIDTH-1:0];
                  data_in_d  = req_data;
                  write_en_d = req_write;
                  read_en_d  = !req_write;
               end
            end
         end

         StIssue: begin
            if (req_write_q) begin
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
               resp_data_d  = '0;
            end else begin
               state_d = StWait;
               cnt_d   = CntW'(READLATENCY - 1);
            end
         end

         StWait: begin
            if (cnt_q == '0) begin
               // Last WAIT cycle: data_out is valid now.
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
               resp_data_d  = data_out;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end

         StResp: begin
            if (resp_ready) begin
               state_d      = StIdle;
               resp_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      req_ready_d = (state_d == StIdle);
   end

   // State and output registers; reset discards any in-flight transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         req_write_q  <= 1'b0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
         address_q    <= '0;
         data_in_q    <= '0;
         write_en_q   <= 1'b0;
         read_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_write_q  <= req_write_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         address_q    <= address_d;
         data_in_q    <= data_in_d;
         write_en_q   <= write_en_d;
         read_en_q    <= read_en_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;
   assign address    = address_q;
   assign data_in    = data_in_q;
   assign write_en   = write_en_q;
   assign read_en    = read_en_q;

endmodule

// File: tb/tb_peripheral_memory_bridge.sv
// Bench for peripheral_memory_bridge: two instances (read latency 1 and 3),
// each attached to a behavioural memory, driven by a vector table, hand
// sequences for stall and mid-read reset, and random traffic against a
// scoreboard memory.

module tb_peripheral_memory_bridge;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;
   localparam int unsigned RAW   = 16;
   localparam int          RL0   = 1;
   localparam int          RL1   = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   logic           req_valid   [2];
   logic           req_ready   [2];
   logic           req_write   [2];
   logic [RAW-1:0] req_address [2];
   logic [DW-1:0]  req_data    [2];
   logic           resp_valid  [2];
   logic           resp_ready  [2];
   logic [DW-1:0]  resp_data   [2];
   logic           resp_error  [2];
   logic [AW-1:0]  address     [2];
   logic [DW-1:0]  data_in     [2];
   logic [DW-1:0]  data_out    [2];
   logic           write_en    [2];
   logic           read_en     [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   peripheral_memory_bridge #(
      .DATAWIDTH(DW), .DATADEPTH(DEPTH), .ADDRESSWIDTH(AW), .REQADDRWIDTH(RAW),
      .READLATENCY(RL0)
   ) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_address(req_address[0]), .req_data(req_data[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
      .resp_error(resp_error[0]),
      .address(address[0]), .data_in(data_in[0]), .data_out(data_out[0]),
      .write_en(write_en[0]), .read_en(read_en[0])
   );

   peripheral_memory_bridge #(
      .DATAWIDTH(DW), .DATADEPTH(DEPTH), .ADDRESSWIDTH(AW), .REQADDRWIDTH(RAW),
      .READLATENCY(RL1)
   ) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_address(req_address[1]), .req_data(req_data[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
      .resp_error(resp_error[1]),
      .address(address[1]), .data_in(data_in[1]), .data_out(data_out[1]),
      .write_en(write_en[1]), .read_en(read_en[1])
   );

   // Behavioural peripheral memory: data_out is valid READLATENCY cycles after
   // the read_en cycle and shows a poison value at any other time.
   logic [DW-1:0] mem    [2][DEPTH];
   logic [DW-1:0] pipe_q [2][4];
   logic          pipe_v [2][4];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[d][i] <= '0;
         end else if (write_en[d]) begin
            mem[d][address[d]] <= data_in[d];
         end
         pipe_v[d][0] <= read_en[d] && !reset;
         pipe_q[d][0] <= mem[d][address[d]];
         for (int s = 1; s < 4; s++) begin
            pipe_v[d][s] <= pipe_v[d][s-1] && !reset;
            pipe_q[d][s] <= pipe_q[d][s-1];
         end
      end
   end

   assign data_out[0] = pipe_v[0][RL0-1] ? pipe_q[0][RL0-1] : 32'hBAD0_BAD0;
   assign data_out[1] = pipe_v[1][RL1-1] ? pipe_q[1][RL1-1] : 32'hBAD0_BAD0;

   // Reference model: a word array per instance, updated by the request rules.
   logic [DW-1:0] sb [2][DEPTH];

   function automatic int rl(input int d);
      return (d == 0) ? RL0 : RL1;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < int'(DEPTH); i++) sb[d][i] = '0;
   endtask

   task automatic model(input int d, input logic wr, input logic [RAW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] exp_data,
                        output logic exp_err);
      exp_err  = (a >= RAW'(DEPTH));
      exp_data = '0;
      if (!exp_err) begin
         if (wr) sb[d][a[AW-1:0]] = wd;
         else    exp_data = sb[d][a[AW-1:0]];
      end
   endtask

   task automatic chk_idle_outputs(input int d);
      chk("rst_resp_valid", resp_valid[d], 0);
      chk("rst_resp_data",  resp_data[d],  0);
      chk("rst_resp_error", resp_error[d], 0);
      chk("rst_address",    address[d],    0);
      chk("rst_data_in",    data_in[d],    0);
      chk("rst_write_en",   write_en[d],   0);
      chk("rst_read_en",    read_en[d],    0);
      chk("rst_req_ready",  req_ready[d],  0);
   endtask

   // One transaction with resp_ready held high; checks strobes, latency and
   // the return to IDLE, and hands back the response for the caller to judge.
   task automatic txn(input int d, input logic wr, input logic [RAW-1:0] a,
                      input logic [DW-1:0] wd, output logic [DW-1:0] rdata,
                      output logic rerr);
      int   lat;
      int   exp_lat;
      int   n;
      logic ok;
      ok      = (a < RAW'(DEPTH));
      exp_lat = !ok ? 1 : (wr ? 2 : 2 + rl(d));
      n       = 0;
      while (!req_ready[d] && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready_before_txn", req_ready[d], 1);
      req_valid[d]   = 1'b1;
      req_write[d]   = wr;
      req_address[d] = a;
      req_data[d]    = wd;
      resp_ready[d]  = 1'b1;
      tick();
      req_valid[d] = 1'b0;
      lat = 1;
      while (!resp_valid[d] && lat < 20) begin
         chk("strobe_exclusive", write_en[d] & read_en[d], 0);
         chk("req_ready_busy", req_ready[d], 0);
         if (lat == 1) begin
            chk("issue_write_en", write_en[d], ok & wr);
            chk("issue_read_en",  read_en[d],  ok & !wr);
            chk("issue_address",  address[d],  a[AW-1:0]);
            if (wr) chk("issue_data_in", data_in[d], wd);
         end else begin
            chk("late_write_en", write_en[d], 0);
            chk("late_read_en",  read_en[d],  0);
         end
         tick();
         lat++;
      end
      chk("resp_latency", lat, exp_lat);
      chk("resp_write_en", write_en[d], 0);
      chk("resp_read_en",  read_en[d],  0);
      rdata = resp_data[d];
      rerr  = resp_error[d];
      tick();
      chk("post_resp_valid", resp_valid[d], 0);
      chk("post_req_ready",  req_ready[d],  1);
   endtask

   typedef struct {
      logic           wr;
      logic [RAW-1:0] a;
      logic [DW-1:0]  wd;
      logic [DW-1:0]  exp_data;
      logic           exp_err;
   } vec_t;

   vec_t vecs [10];

   logic [DW-1:0] got_data, exp_data;
   logic          got_err, exp_err;
   int            n;

   initial begin
      vecs[0] = '{1'b1, 16'd5,      32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1] = '{1'b0, 16'd5,      32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b0, 16'd256,    32'h0,         32'h0,         1'b1};
      vecs[3] = '{1'b1, 16'd255,    32'h1234_5678, 32'h0,         1'b0};
      vecs[4] = '{1'b0, 16'd255,    32'h0,         32'h1234_5678, 1'b0};
      vecs[5] = '{1'b1, 16'd256,    32'hAAAA_AAAA, 32'h0,         1'b1};
      vecs[6] = '{1'b0, 16'd0,      32'h0,         32'h0,         1'b0};
      vecs[7] = '{1'b1, 16'd0,      32'hCAFE_F00D, 32'h0,         1'b0};
      vecs[8] = '{1'b0, 16'd0,      32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[9] = '{1'b1, 16'hFFFF,   32'h5555_5555, 32'h0,         1'b1};

      for (int d = 0; d < 2; d++) begin
         req_valid[d]   = 1'b0;
         req_write[d]   = 1'b0;
         req_address[d] = '0;
         req_data[d]    = '0;
         resp_ready[d]  = 1'b0;
      end
      sb_clear();
      #1 reset = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 2; d++) chk_idle_outputs(d);
      reset = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) chk("req_ready_after_reset", req_ready[d], 1);

      // Vector table on both latencies.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 10; i++) begin
            model(d, vecs[i].wr, vecs[i].a, vecs[i].wd, exp_data, exp_err);
            txn(d, vecs[i].wr, vecs[i].a, vecs[i].wd, got_data, got_err);
            chk("vec_resp_data",  got_data, vecs[i].exp_data);
            chk("vec_resp_error", got_err,  vecs[i].exp_err);
         end
      end

      // Response stall with a competing request held during the stall.
      for (int d = 0; d < 2; d++) begin
         model(d, 1'b0, 16'd5, 32'h0, exp_data, exp_err);
         chk("stall_req_ready", req_ready[d], 1);
         req_valid[d]   = 1'b1;
         req_write[d]   = 1'b0;
         req_address[d] = 16'd5;
         resp_ready[d]  = 1'b0;
         tick();
         req_valid[d] = 1'b0;
         n = 0;
         while (!resp_valid[d] && n < 20) begin
            tick();
            n++;
         end
         chk("stall_resp_seen", resp_valid[d], 1);
         req_valid[d]   = 1'b1;
         req_write[d]   = 1'b1;
         req_address[d] = 16'd9;
         req_data[d]    = 32'h1111_2222;
         for (int k = 0; k < 10; k++) begin
            chk("stall_resp_valid", resp_valid[d], 1);
            chk("stall_resp_data",  resp_data[d],  exp_data);
            chk("stall_resp_error", resp_error[d], 0);
            chk("stall_req_ready",  req_ready[d],  0);
            chk("stall_write_en",   write_en[d],   0);
            tick();
         end
         resp_ready[d] = 1'b1;
         tick();
         chk("unstall_resp_valid", resp_valid[d], 0);
         chk("unstall_req_ready",  req_ready[d],  1);
         chk("unstall_write_en",   write_en[d],   0);
         tick();
         req_valid[d] = 1'b0;
         model(d, 1'b1, 16'd9, 32'h1111_2222, exp_data, exp_err);
         chk("queued_write_en", write_en[d], 1);
         chk("queued_address",  address[d],  9);
         chk("queued_data_in",  data_in[d],  32'h1111_2222);
         n = 0;
         while (!resp_valid[d] && n < 20) begin
            tick();
            n++;
         end
         chk("queued_resp_valid", resp_valid[d], 1);
         chk("queued_resp_error", resp_error[d], 0);
         tick();
      end

      // Reset in the middle of a latency-3 read.
      req_valid[1]   = 1'b1;
      req_write[1]   = 1'b0;
      req_address[1] = 16'd9;
      resp_ready[1]  = 1'b1;
      chk("wait_req_ready", req_ready[1], 1);
      tick();
      req_valid[1] = 1'b0;
      chk("wait_issue_read_en", read_en[1], 1);
      tick();
      reset = 1'b1;
      #1;
      chk_idle_outputs(1);
      tick();
      sb_clear();
      reset = 1'b0;
      tick();
      chk("wait_rst_req_ready", req_ready[1], 1);
      for (int k = 0; k < 8; k++) begin
         chk("no_stale_resp", resp_valid[1], 0);
         tick();
      end

      // Random traffic against the reference model.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 100; i++) begin
            logic           wr;
            logic [RAW-1:0] a;
            logic [DW-1:0]  wd;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = RAW'(256 + $urandom_range(0, 2000));
            else                           a = RAW'($urandom_range(0, 31));
            wd = $urandom;
            model(d, wr, a, wd, exp_data, exp_err);
            txn(d, wr, a, wd, got_data, got_err);
            chk("rand_resp_data",  got_data, exp_data);
            chk("rand_resp_error", got_err,  exp_err);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
